// File: rtl/stream_merger.sv
// ============================================================================
// Module   : stream_merger
// Function : two-into-one valid/ready merger, round-robin arbitration,
//            2-entry tagged output buffer. Optional grant lock via the
//            STREAM_MERGER_LOCK_EN macro (locks grant for BEATS transfers).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module stream_merger #(
  parameter int WIDTH = 32,
  parameter int BEATS = 4
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iValid_AM0,
  output logic             oReady_AM0,
  input  logic [WIDTH-1:0] iData_AM0,
  input  logic             iValid_AM1,
  output logic             oReady_AM1,
  input  logic [WIDTH-1:0] iData_AM1,
  output logic             oValid_BM,
  input  logic             iReady_BM,
  output logic             oSelect_BM,
  output logic [WIDTH-1:0] oData_BM
);

  if ((BEATS < 1) || (BEATS > 256)) begin : g_beats_range_err
    $error("stream_merger: BEATS must be in 1..256");
  end

  logic [1:0]     count;
  logic           last;
  logic [WIDTH:0] entry0;   // FIFO head, {select, data}
  logic [WIDTH:0] entry1;

  logic           rr_grant;
  logic           grant;
  logic           space;
  logic           xfer0;
  logic           xfer1;
  logic           push;
  logic           pop;
  logic           push_sel;
  logic [WIDTH:0] push_word;

  always_comb begin
    rr_grant = ~last;
    if (iValid_AM0 && !iValid_AM1) begin
      rr_grant = 1'b0;
    end else if (iValid_AM1 && !iValid_AM0) begin
      rr_grant = 1'b1;
    end
  end

`ifdef STREAM_MERGER_LOCK_EN
  localparam logic [7:0] LOCK_LAST  = 8'(BEATS - 1);
  localparam bit         LOCK_MULTI = (BEATS > 1);

  logic [7:0] lock_cnt;     // beats accepted so far in the active lock
  logic       lock_src;
  logic       lock_active;

  assign lock_active = (lock_cnt != 8'd0);
  assign grant       = lock_active ? lock_src : rr_grant;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      lock_cnt <= 8'd0;
      lock_src <= 1'b0;
    end else if (push) begin
      if (lock_active) begin
        if (lock_cnt == LOCK_LAST) begin
          lock_cnt <= 8'd0;
        end else begin
          lock_cnt <= lock_cnt + 8'd1;
        end
      end else if (LOCK_MULTI) begin
        lock_cnt <= 8'd1;
        lock_src <= push_sel;
      end
    end
  end
`else
  assign grant = rr_grant;
`endif

  // Space ignores a same-cycle pop so input readies never see iReady_BM.
  assign space      = (count != 2'd2);
  assign oReady_AM0 = space && (grant == 1'b0);
  assign oReady_AM1 = space && (grant == 1'b1);

  assign xfer0     = iValid_AM0 && oReady_AM0;
  assign xfer1     = iValid_AM1 && oReady_AM1;
  assign push      = xfer0 || xfer1;
  assign push_sel  = xfer1;
  assign push_word = xfer1 ? {1'b1, iData_AM1} : {1'b0, iData_AM0};

  assign oValid_BM  = (count != 2'd0);
  assign pop        = oValid_BM && iReady_BM;
  assign oSelect_BM = entry0[WIDTH];
  assign oData_BM   = entry0[WIDTH-1:0];

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      count  <= 2'd0;
      last   <= 1'b1;
      entry0 <= '0;
      entry1 <= '0;
    end else begin
      if (push) begin
        last <= push_sel;
      end
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            entry0 <= push_word;
          end else begin
            entry1 <= push_word;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          entry0 <= entry1;
          count  <= count - 2'd1;
        end
        2'b11: begin
          // push implies count<2 and pop implies count>0, so count==1 here
          entry0 <= push_word;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stream_merger.sv
// ============================================================================
// Module   : tb_stream_merger
// Function : directed and randomised self-checking bench for stream_merger.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_stream_merger;

  localparam int W = 8;
  localparam int N_RAND = 3000;

  logic         clk = 1'b0;
  logic         rst;
  logic         v0, r0, v1, r1, ov, ordy, osel;
  logic [W-1:0] d0, d1, od;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stream_merger #(.WIDTH(W), .BEATS(3)) dut (
    .iCLK       (clk),
    .iRST       (rst),
    .iValid_AM0 (v0),
    .oReady_AM0 (r0),
    .iData_AM0  (d0),
    .iValid_AM1 (v1),
    .oReady_AM1 (r1),
    .iData_AM1  (d1),
    .oValid_BM  (ov),
    .iReady_BM  (ordy),
    .oSelect_BM (osel),
    .oData_BM   (od)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic a, input logic [W-1:0] da, input logic b,
                       input logic [W-1:0] db, input logic r);
    v0 = a; d0 = da; v1 = b; d1 = db; ordy = r;
    #1;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic s, input logic [W-1:0] d);
    check({tag, "_valid"}, ov, v);
    check({tag, "_sel"}, osel, s);
    check({tag, "_data"}, od, d);
  endtask

  task automatic expect_rdy(input string tag, input logic e0, input logic e1);
    check({tag, "_ready0"}, r0, e0);
    check({tag, "_ready1"}, r1, e1);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    tick;
    tick;
    rst = 1'b0;
    #1;
  endtask

  logic         a0, a1, x0, x1;
  logic [6:0]   c0, c1;
  logic [W-1:0] da, db;
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];

  initial begin
    rst = 1'b1;
    v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0; ordy = 1'b0;
    @(negedge clk);

    // reset state
    do_reset;
    expect_out("reset", 1'b0, 1'b0, 8'h00);
    expect_rdy("reset", 1'b1, 1'b0);

    // source 0 alone
    drive(1'b1, 8'h0A, 1'b0, 8'h00, 1'b1);
    expect_rdy("solo_a", 1'b1, 1'b0);
    tick;
    expect_out("solo_a", 1'b1, 1'b0, 8'h0A);
    drive(1'b1, 8'h0B, 1'b0, 8'h00, 1'b1);
    expect_rdy("solo_b", 1'b1, 1'b0);
    tick;
    expect_out("solo_b", 1'b1, 1'b0, 8'h0B);
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    tick;
    check("solo_drained_valid", ov, 1'b0);

    // alternating contention
    do_reset;
    drive(1'b1, 8'h10, 1'b1, 8'h20, 1'b1);
    expect_rdy("rr0", 1'b1, 1'b0);
    tick;
    expect_out("rr0", 1'b1, 1'b0, 8'h10);
    drive(1'b1, 8'h11, 1'b1, 8'h20, 1'b1);
    expect_rdy("rr1", 1'b0, 1'b1);
    tick;
    expect_out("rr1", 1'b1, 1'b1, 8'h20);
    drive(1'b1, 8'h11, 1'b1, 8'h21, 1'b1);
    expect_rdy("rr2", 1'b1, 1'b0);
    tick;
    expect_out("rr2", 1'b1, 1'b0, 8'h11);
    drive(1'b1, 8'h12, 1'b1, 8'h21, 1'b1);
    expect_rdy("rr3", 1'b0, 1'b1);
    tick;
    expect_out("rr3", 1'b1, 1'b1, 8'h21);

    // backpressure fills two entries, then drains in order
    do_reset;
    drive(1'b1, 8'h30, 1'b1, 8'h40, 1'b0);
    expect_rdy("bp0", 1'b1, 1'b0);
    tick;
    expect_out("bp0", 1'b1, 1'b0, 8'h30);
    drive(1'b1, 8'h31, 1'b1, 8'h40, 1'b0);
`ifndef STREAM_MERGER_LOCK_EN
    expect_rdy("bp1", 1'b0, 1'b1);
    tick;
    expect_out("bp1", 1'b1, 1'b0, 8'h30);
    drive(1'b1, 8'h31, 1'b1, 8'h41, 1'b0);
    expect_rdy("bp_full", 1'b0, 1'b0);
    tick;
    expect_out("bp_hold", 1'b1, 1'b0, 8'h30);
    expect_rdy("bp_hold", 1'b0, 1'b0);
    drive(1'b1, 8'h31, 1'b1, 8'h41, 1'b1);
    expect_rdy("bp_pop_no_space", 1'b0, 1'b0);
    tick;
    expect_out("bp_d0", 1'b1, 1'b1, 8'h40);
    expect_rdy("bp_d0", 1'b1, 1'b0);
    tick;
    expect_out("bp_d1", 1'b1, 1'b0, 8'h31);
    drive(1'b1, 8'h32, 1'b1, 8'h41, 1'b1);
    expect_rdy("bp_d1", 1'b0, 1'b1);
    tick;
    expect_out("bp_d2", 1'b1, 1'b1, 8'h41);
`endif

    // reset with a full buffer (and an active lock in the lock build)
    do_reset;
    drive(1'b1, 8'h70, 1'b1, 8'h80, 1'b0);
    tick;
    drive(1'b1, 8'h71, 1'b1, 8'h80, 1'b0);
    tick;
    expect_rdy("mid_full", 1'b0, 1'b0);
    rst = 1'b1;
    drive(1'b1, 8'h72, 1'b1, 8'h80, 1'b0);
    tick;
    expect_out("mid_rst", 1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    drive(1'b1, 8'h72, 1'b1, 8'h81, 1'b1);
    expect_rdy("post_rst", 1'b1, 1'b0);
    tick;
    expect_out("post_rst", 1'b1, 1'b0, 8'h72);

`ifdef STREAM_MERGER_LOCK_EN
    // BEATS=3 lock: sel 0,0,0,1,1,1,0
    begin
      logic [W-1:0] exp_d[7] = '{8'h50, 8'h51, 8'h52, 8'h60, 8'h61, 8'h62, 8'h53};
      logic         exp_s[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [W-1:0] n0, n1;
      logic         took0;
      do_reset;
      n0 = 8'h50; n1 = 8'h60;
      for (int k = 0; k < 7; k++) begin
        drive(1'b1, n0, 1'b1, n1, 1'b1);
        took0 = r0;
        tick;
        expect_out($sformatf("lock%0d", k), 1'b1, exp_s[k], exp_d[k]);
        if (took0) n0 = n0 + 8'd1;
        else       n1 = n1 + 8'd1;
      end
    end
    // source 0 drops valid mid-lock: source 1 stays blocked
    do_reset;
    drive(1'b1, 8'h50, 1'b1, 8'h60, 1'b1);
    tick;
    drive(1'b0, 8'h00, 1'b1, 8'h60, 1'b1);
    expect_rdy("lock_gap0", 1'b1, 1'b0);
    tick;
    expect_rdy("lock_gap1", 1'b1, 1'b0);
    drive(1'b1, 8'h51, 1'b1, 8'h60, 1'b1);
    tick;
    drive(1'b1, 8'h52, 1'b1, 8'h60, 1'b1);
    expect_rdy("lock_beat3", 1'b1, 1'b0);
    tick;
    drive(1'b0, 8'h00, 1'b1, 8'h60, 1'b1);
    expect_rdy("lock_release", 1'b0, 1'b1);
    tick;
`endif

    // randomised traffic against per-source queues
    do_reset;
    a0 = 1'b0; a1 = 1'b0; c0 = '0; c1 = '0; da = '0; db = '0;
    for (int i = 0; i < N_RAND + 40; i++) begin
      if (!a0 && i < N_RAND && $urandom_range(0, 3) != 0) begin
        a0 = 1'b1; da = {1'b0, c0}; c0 = c0 + 7'd1;
      end
      if (!a1 && i < N_RAND && $urandom_range(0, 3) != 0) begin
        a1 = 1'b1; db = {1'b1, c1}; c1 = c1 + 7'd1;
      end
      drive(a0, da, a1, db, $urandom_range(0, 3) != 0);
      if (ov && ordy) begin
        if (osel == 1'b0) begin
          if (q0.size() == 0) check("rand_src0_extra", 1'b1, 1'b0);
          else                check("rand_src0_data", od, q0.pop_front());
        end else begin
          if (q1.size() == 0) check("rand_src1_extra", 1'b1, 1'b0);
          else                check("rand_src1_data", od, q1.pop_front());
        end
      end
      x0 = a0 && r0;
      x1 = a1 && r1;
      if (x0 && x1) check("rand_double_accept", 1'b1, 1'b0);
      if (x0) q0.push_back(da);
      if (x1) q1.push_back(db);
      tick;
      if (x0) a0 = 1'b0;
      if (x1) a1 = 1'b0;
    end
    check("rand_src0_lost", q0.size(), 0);
    check("rand_src1_lost", q1.size(), 0);
    check("rand_pending0", a0, 1'b0);
    check("rand_pending1", a1, 1'b0);
    check("rand_final_valid", ov, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
